// File: rtl/karsilastirici_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package karsilastirici_pkg;

    // Controller states: idle and comparing.
    typedef enum logic {
        BOS  = 1'b0,
        KARS = 1'b1
    } durum_t;

    // First-mismatch encoding; bit 0 marks A<B, bit 1 marks A>B.
    localparam logic [1:0] ESIT  = 2'b00;
    localparam logic [1:0] KUCUK = 2'b01;
    localparam logic [1:0] BUYUK = 2'b10;

endpackage

// File: rtl/bit_karsilastirici.sv
// Existing 1-bit comparator stage: one-hot less / equal / greater for a bit pair.
module bit_karsilastirici (
    input  logic A,
    input  logic B,
    output logic AkB,
    output logic AeB,
    output logic AbB
);

    // Purely combinational decode of the bit pair.
    always_comb begin
        AkB = ~A & B;
        AeB = ~(A ^ B);
        AbB = A & ~B;
    end

endmodule

// File: rtl/seri_karsilastirici.sv
// Serial N-bit magnitude comparator: shifts captured operands MSB-first through
// the 1-bit stage and records the first non-equal decision.
module seri_karsilastirici #(
    parameter int N           = 8,
    parameter int ERKEN_CIKIS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   basla,
    input  logic [N-1:0]           A,
    input  logic [N-1:0]           B,
    output logic                   mesgul,
    output logic                   bitti,
    output logic                   AkB,
    output logic                   AeB,
    output logic                   AbB,
    output logic [$clog2(N+1)-1:0] dongu
);
    import karsilastirici_pkg::*;

    localparam int             CW  = $clog2(N + 1);
    localparam logic [CW-1:0]  SON = CW'(N - 1);
    localparam logic           ERKEN = (ERKEN_CIKIS != 0);

    durum_t        durum, sonrakiDurum;
    logic [N-1:0]  sa, sb;
    logic [CW-1:0] sayac;
    logic [1:0]    ilkFark;
    logic          bitAkB, bitAeB, bitAbB;
    logic          karar;
    logic [1:0]    sonuc;

    bit_karsilastirici uBit (
        .A   (sa[N-1]),
        .B   (sb[N-1]),
        .AkB (bitAkB),
        .AeB (bitAeB),
        .AbB (bitAbB)
    );

    // Decision detection and the result to be registered on a decision edge.
    // A latched earlier mismatch wins over the current bit; with no latched
    // mismatch the current bit decides (equal when it matches too).
    always_comb begin
        karar = (durum == KARS) && ((ERKEN && !bitAeB) || (sayac == SON));
        sonuc = (ilkFark != ESIT) ? ilkFark : {bitAbB, bitAkB};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) durum <= BOS;
        else     durum <= sonrakiDurum;
    end

    // Next-state logic: start from idle, return on a decision.
    always_comb begin
        sonrakiDurum = durum;
        case (durum)
            BOS:     if (basla) sonrakiDurum = KARS;
            KARS:    if (karar) sonrakiDurum = BOS;
            default: sonrakiDurum = BOS;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        mesgul = (durum == KARS);
    end

    // Datapath: operand capture, shifting, mismatch latch and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            sayac   <= '0;
            ilkFark <= ESIT;
            bitti   <= 1'b0;
            AkB     <= 1'b0;
            AeB     <= 1'b0;
            AbB     <= 1'b0;
            dongu   <= '0;
        end else begin
            bitti <= 1'b0;
            if (durum == BOS) begin
                if (basla) begin
                    sa      <= A;
                    sb      <= B;
                    sayac   <= '0;
                    ilkFark <= ESIT;
                end
            end else if (karar) begin
                bitti <= 1'b1;
                AkB   <= (sonuc == KUCUK);
                AeB   <= (sonuc == ESIT);
                AbB   <= (sonuc == BUYUK);
                dongu <= sayac + CW'(1);
            end else begin
                sa    <= {sa[N-2:0], 1'b0};
                sb    <= {sb[N-2:0], 1'b0};
                sayac <= sayac + CW'(1);
                if (ilkFark == ESIT && !bitAeB)
                    ilkFark <= {bitAbB, bitAkB};
            end
        end
    end

endmodule

// File: tb/tb_seri_karsilastirici.sv
// Self-checking bench for seri_karsilastirici: instance 0 stops early,
// instance 1 always consumes all bits.
module tb_seri_karsilastirici;

    localparam int N = 8;

    logic       clk;
    logic       rst;
    logic       basla  [2];
    logic [7:0] opA    [2];
    logic [7:0] opB    [2];
    logic       mesgul [2];
    logic       bitti  [2];
    logic       AkB    [2];
    logic       AeB    [2];
    logic       AbB    [2];
    logic [3:0] dongu  [2];

    int checks = 0;
    int errors = 0;

    seri_karsilastirici #(.N(N), .ERKEN_CIKIS(1)) dutErken (
        .clk(clk), .rst(rst), .basla(basla[0]), .A(opA[0]), .B(opB[0]),
        .mesgul(mesgul[0]), .bitti(bitti[0]), .AkB(AkB[0]), .AeB(AeB[0]),
        .AbB(AbB[0]), .dongu(dongu[0])
    );

    seri_karsilastirici #(.N(N), .ERKEN_CIKIS(0)) dutTam (
        .clk(clk), .rst(rst), .basla(basla[1]), .A(opA[1]), .B(opB[1]),
        .mesgul(mesgul[1]), .bitti(bitti[1]), .AkB(AkB[1]), .AeB(AeB[1]),
        .AbB(AbB[1]), .dongu(dongu[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: cycles needed is the 1-based MSB position of the first
    // differing bit in early-exit mode, otherwise always N.
    function automatic int expLat(input logic [7:0] a, input logic [7:0] b, input int idx);
        if (idx == 1) return N;
        for (int i = N - 1; i >= 0; i--)
            if (a[i] != b[i]) return N - i;
        return N;
    endfunction

    task automatic chkIdle(input int idx, input string tag);
        chk({tag, "_mesgul"}, mesgul[idx], 0);
        chk({tag, "_bitti"},  bitti[idx],  0);
        chk({tag, "_AkB"},    AkB[idx],    0);
        chk({tag, "_AeB"},    AeB[idx],    0);
        chk({tag, "_AbB"},    AbB[idx],    0);
        chk({tag, "_dongu"},  dongu[idx],  0);
    endtask

    // One comparison. b2b: caller is already at the negedge of a bitti cycle.
    // glitch: pulse basla mid-run and verify nothing extra follows.
    task automatic doCompare(input int idx, input logic [7:0] a, input logic [7:0] b,
                             input bit b2b, input bit glitch, input string tag);
        int  k;
        int  cyc;
        bit  found;
        bit  doGlitch;
        k = expLat(a, b, idx);
        doGlitch = glitch && (k >= 4);
        if (!b2b) @(negedge clk);
        basla[idx] = 1'b1;
        opA[idx]   = a;
        opB[idx]   = b;
        @(posedge clk);
        @(negedge clk);
        basla[idx] = 1'b0;
        opA[idx]   = 8'($urandom);
        opB[idx]   = 8'($urandom);
        chk({tag, "_busy"}, mesgul[idx], 1);
        chk({tag, "_nobitti"}, bitti[idx], 0);
        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < N + 4) begin
            if (doGlitch && cyc == 1) basla[idx] = 1'b1;
            if (doGlitch && cyc == 2) basla[idx] = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bitti[idx]) found = 1'b1;
        end
        basla[idx] = 1'b0;
        chk({tag, "_done"},  found, 1);
        chk({tag, "_lat"},   cyc,   k);
        chk({tag, "_AkB"},   AkB[idx], (a < b));
        chk({tag, "_AeB"},   AeB[idx], (a == b));
        chk({tag, "_AbB"},   AbB[idx], (a > b));
        chk({tag, "_dongu"}, dongu[idx], k);
        chk({tag, "_idle"},  mesgul[idx], 0);
        if (doGlitch) begin
            @(negedge clk);
            chk({tag, "_noextra"}, bitti[idx], 0);
            chk({tag, "_stillidle"}, mesgul[idx], 0);
            chk({tag, "_hold"}, AeB[idx], (a == b));
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        bit         lastGlitch;
        bit         g;
        int         seen;
        for (int i = 0; i < 2; i++) begin
            basla[i] = 1'b0;
            opA[i]   = '0;
            opB[i]   = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chkIdle(0, "rst0");
        chkIdle(1, "rst1");

        // Directed cases from the plan.
        doCompare(0, 8'hA5, 8'hA5, 0, 0, "eqA5");
        doCompare(0, 8'h80, 8'h7F, 0, 0, "msb");
        doCompare(0, 8'h12, 8'h13, 0, 0, "lsb");
        doCompare(1, 8'h40, 8'h3F, 0, 0, "full");
        doCompare(1, 8'h00, 8'h01, 0, 0, "fullLsb");
        doCompare(1, 8'h77, 8'h77, 0, 0, "fullEq");

        // Back-to-back accept in the bitti cycle, then ignored basla while busy.
        doCompare(0, 8'hF0, 8'h0F, 0, 0, "pre");
        doCompare(0, 8'd3,  8'd5,  1, 0, "b2b");
        doCompare(0, 8'h01, 8'h01, 1, 1, "glitch0");
        doCompare(1, 8'h20, 8'h10, 0, 0, "pre1");
        doCompare(1, 8'd3,  8'd5,  1, 1, "b2bGlitch1");

        // Reset in the middle of a comparison.
        @(negedge clk);
        basla[1] = 1'b1;
        opA[1]   = 8'h01;
        opB[1]   = 8'h02;
        @(posedge clk);
        @(negedge clk);
        basla[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chkIdle(1, "midRst1");
        chkIdle(0, "midRst0");
        seen = 0;
        repeat (N + 2) begin
            @(negedge clk);
            if (bitti[1]) seen++;
        end
        chk("midRst_nobitti", seen, 0);
        doCompare(1, 8'h01, 8'h02, 0, 0, "afterRst");

        // Randomized comparisons on both instances.
        for (int idx = 0; idx < 2; idx++) begin
            lastGlitch = 1'b1;
            for (int i = 0; i < 16; i++) begin
                ra = 8'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
                if ($urandom_range(0, 2) == 0) rb = ra ^ (8'h01 << $urandom_range(0, 7));
                g = (i % 3 == 0);
                doCompare(idx, ra, rb, !lastGlitch, g, "rnd");
                lastGlitch = g && (expLat(ra, rb, idx) >= 4);
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
